// File: rtl/prog_counter_stack_pkg.sv
// Shared definitions for the program counter with return-address stack:
// default widths/depth and the op-priority encoding used by the top level.
package prog_counter_stack_pkg;

  // Default configuration of the 8-bit processor's PC.
  localparam int PC_W_DEF  = 4;
  localparam int OFF_W_DEF = 4;
  localparam int RAS_D_DEF = 4;

  // Selected operation for one cycle, after priority resolution.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_EN   = 3'd1,
    OP_REL  = 3'd2,
    OP_LOAD = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } pc_op_e;

  // Priority resolution: ret > call > load > rel > en; lower strobes are ignored.
  function automatic pc_op_e pick_op(input logic ret, input logic call,
                                     input logic load, input logic rel,
                                     input logic en);
    pc_op_e op;
    if (ret) begin
      op = OP_RET;
    end else if (call) begin
      op = OP_CALL;
    end else if (load) begin
      op = OP_LOAD;
    end else if (rel) begin
      op = OP_REL;
    end else if (en) begin
      op = OP_EN;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack: DEPTH entries of W bits, LIFO with an occupancy count.
// Push when full and pop when empty are ignored (contents and count unchanged).
// full_q/empty_q are registered and derived from the next count.
module pc_ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_val,
  output logic [W-1:0] top,
  output logic         full_q,
  output logic         empty_q
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full_d;
  logic             empty_d;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;

  // Next free slot is at cnt; the top of stack is one below it.
  assign wr_idx_s = IDX_W'(cnt_q);
  assign rd_idx_s = IDX_W'(cnt_q - CNT_W'(1));
  assign top      = mem_q[rd_idx_s];

  // Next-state for storage and count; pop wins if both are requested.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop && !empty_q) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push && !full_q) begin
      mem_d[wr_idx_s] = push_val;
      cnt_d           = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    full_d  = (cnt_d == CNT_W'(DEPTH));
    empty_d = (cnt_d == CNT_W'(0));
  end

  // Stack registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      cnt_q   <= {CNT_W{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: rtl/prog_counter_stack.sv
// Parametrised program counter with relative branch and call/return through
// an internal return-address stack; drives the shared bus through a tri-state.
// Optional sticky stack-error flag when PC_RAS_ERR_EN is defined.
module prog_counter_stack
  import prog_counter_stack_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF,
  parameter int RAS_D = RAS_D_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             load,
  input  logic             rel,
  input  logic             call,
  input  logic             ret,
  input  logic [PC_W-1:0]  load_val,
  input  logic [OFF_W-1:0] rel_off,
  input  logic             bus_oe,
  inout  wire  [PC_W-1:0]  pc_bus,
  output logic [PC_W-1:0]  pc_q,
`ifdef PC_RAS_ERR_EN
  output logic             ras_err,
`endif
  output logic             ras_full,
  output logic             ras_empty
);

  pc_op_e          op_s;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] off_ext_s;
  logic [PC_W-1:0] ras_top_s;
  logic            push_s;
  logic            pop_s;

  assign op_s      = pick_op(ret, call, load, rel, en);
  assign pc_inc_s  = pc_q + PC_W'(1);
  // Signed cast sign-extends the offset to PC width; sums wrap mod 2^PC_W.
  assign off_ext_s = PC_W'($signed(rel_off));
  assign push_s    = (op_s == OP_CALL);
  assign pop_s     = (op_s == OP_RET);

  pc_ret_stack #(
    .DEPTH (RAS_D),
    .W     (PC_W)
  ) u_ras (
    .clk      (clk),
    .clr_n    (clr_n),
    .push     (push_s),
    .pop      (pop_s),
    .push_val (pc_inc_s),
    .top      (ras_top_s),
    .full_q   (ras_full),
    .empty_q  (ras_empty)
  );

  // Op-select mux for the next PC.
  always_comb begin
    pc_d = pc_q;
    case (op_s)
      OP_RET: begin
        if (!ras_empty) begin
          pc_d = ras_top_s;
        end else begin
          pc_d = pc_q;
        end
      end
      OP_CALL: pc_d = load_val;
      OP_LOAD: pc_d = load_val;
      OP_REL:  pc_d = pc_q + off_ext_s;
      OP_EN:   pc_d = pc_inc_s;
      default: pc_d = pc_q;
    endcase
  end

  // PC register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc_q <= {PC_W{1'b0}};
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_RAS_ERR_EN
  logic ras_err_q;
  logic ras_err_d;

  // Sticky error: call while full or ret while empty.
  always_comb begin
    ras_err_d = ras_err_q | (push_s & ras_full) | (pop_s & ras_empty);
  end

  // Error flag register, cleared only by clr_n.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ras_err_q <= 1'b0;
    end else begin
      ras_err_q <= ras_err_d;
    end
  end

  assign ras_err = ras_err_q;
`endif

  // Tri-state bus driver, combinational from the PC register.
  assign pc_bus = bus_oe ? pc_q : {PC_W{1'bz}};

endmodule

// File: tb/tb_prog_counter_stack.sv
// Directed self-checking bench for prog_counter_stack (PC_W=4, OFF_W=4, RAS_D=4).
// Define PC_RAS_ERR_EN for both bench and RTL to exercise the sticky error flag.
module tb_prog_counter_stack;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       en, load, rel, call, ret, bus_oe;
  logic [3:0] load_val;
  logic [3:0] rel_off;
  wire  [3:0] pc_bus;
  logic [3:0] pc_q;
  logic       ras_full, ras_empty;
`ifdef PC_RAS_ERR_EN
  logic       ras_err;
`endif
  logic       tb_drv_oe;
  logic [3:0] tb_drv_val;

  int checks   = 0;
  int failures = 0;

  assign pc_bus = tb_drv_oe ? tb_drv_val : 4'bzzzz;

  always #5 clk = ~clk;

  prog_counter_stack #(.PC_W(4), .OFF_W(4), .RAS_D(4)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .en        (en),
    .load      (load),
    .rel       (rel),
    .call      (call),
    .ret       (ret),
    .load_val  (load_val),
    .rel_off   (rel_off),
    .bus_oe    (bus_oe),
    .pc_bus    (pc_bus),
    .pc_q      (pc_q),
`ifdef PC_RAS_ERR_EN
    .ras_err   (ras_err),
`endif
    .ras_full  (ras_full),
    .ras_empty (ras_empty)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ops_idle();
    en = 1'b0; load = 1'b0; rel = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    ops_idle(); load = 1'b1; load_val = v; step(); load = 1'b0;
  endtask

  task automatic do_call(input logic [3:0] v);
    ops_idle(); call = 1'b1; load_val = v; step(); call = 1'b0;
  endtask

  task automatic do_ret();
    ops_idle(); ret = 1'b1; step(); ret = 1'b0;
  endtask

  initial begin
    clr_n = 1'b0; bus_oe = 1'b0; load_val = 4'h0; rel_off = 4'h0;
    tb_drv_oe = 1'b0; tb_drv_val = 4'h0;
    ops_idle();

    // 1 Reset overrides en, then three increments.
    en = 1'b1;
    step(); step();
    chk("rst_pc", pc_q, 16'h0);
    chk("rst_empty", ras_empty, 16'h1);
    chk("rst_full", ras_full, 16'h0);
`ifdef PC_RAS_ERR_EN
    chk("rst_err", ras_err, 16'h0);
`endif
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("en_x3", pc_q, 16'h3);

    // 2 Wrap on increment and relative jumps both ways.
    do_load(4'hE);
    chk("load_e", pc_q, 16'hE);
    en = 1'b1;
    step(); chk("wrap_f", pc_q, 16'hF);
    step(); chk("wrap_0", pc_q, 16'h0);
    step(); chk("wrap_1", pc_q, 16'h1);
    ops_idle(); rel = 1'b1; rel_off = 4'hE;
    step(); chk("rel_neg", pc_q, 16'hF);
    rel_off = 4'h3;
    step(); chk("rel_pos", pc_q, 16'h2);
    ops_idle();
    step(); chk("hold", pc_q, 16'h2);

    // 3 Call then return.
    do_load(4'h5);
    do_call(4'h9);
    chk("call_pc", pc_q, 16'h9);
    chk("call_nempty", ras_empty, 16'h0);
    do_ret();
    chk("ret_pc", pc_q, 16'h6);
    chk("ret_empty", ras_empty, 16'h1);

    // 4 Overflow: pushes 7,2,3,4; fifth push (5) dropped.
    do_call(4'h1);
    do_call(4'h2);
    do_call(4'h3);
    chk("full_n3", ras_full, 16'h0);
    do_call(4'h4);
    chk("full_4", ras_full, 16'h1);
    do_call(4'h8);
    chk("call5_pc", pc_q, 16'h8);
    chk("call5_full", ras_full, 16'h1);
    do_ret(); chk("ret1", pc_q, 16'h4);
    chk("ret1_full", ras_full, 16'h0);
    do_ret(); chk("ret2", pc_q, 16'h3);
    do_ret(); chk("ret3", pc_q, 16'h2);
    do_ret(); chk("ret4", pc_q, 16'h7);
    chk("ret4_empty", ras_empty, 16'h1);
    do_ret(); chk("ret5_hold", pc_q, 16'h7);
    chk("ret5_empty", ras_empty, 16'h1);
`ifdef PC_RAS_ERR_EN
    chk("ovf_err", ras_err, 16'h1);
`endif

    // 5 Priority: stack holds 1,3; ret beats call/load/en.
    do_load(4'h0);
    do_call(4'h2);
    do_call(4'hA);
    ops_idle(); ret = 1'b1; call = 1'b1; load = 1'b1; en = 1'b1; load_val = 4'h7;
    step();
    chk("prio_ret", pc_q, 16'h3);
    chk("prio_cnt_nempty", ras_empty, 16'h0);
    do_ret();
    chk("prio_ret2", pc_q, 16'h1);
    chk("prio_cnt_empty", ras_empty, 16'h1);
    ops_idle(); load = 1'b1; en = 1'b1; load_val = 4'h7;
    step(); chk("prio_load", pc_q, 16'h7);
    ops_idle(); rel = 1'b1; en = 1'b1; rel_off = 4'h3;
    step(); chk("prio_rel", pc_q, 16'hA);
    ops_idle();

    // 6 Tri-state bus and reset during a call.
    bus_oe = 1'b0; tb_drv_oe = 1'b1; tb_drv_val = 4'h9;
    #1; chk("bus_z", pc_bus, 16'h9);
    tb_drv_oe = 1'b0; bus_oe = 1'b1;
    #1; chk("bus_drive", pc_bus, 16'hA);
    do_call(4'h5);
    chk("bus_follow", pc_bus, 16'h5);
    chk("pre_clr_nempty", ras_empty, 16'h0);
    ops_idle(); call = 1'b1; load_val = 4'h6; clr_n = 1'b0;
    step();
    chk("clr_pc", pc_q, 16'h0);
    chk("clr_empty", ras_empty, 16'h1);
    chk("clr_bus", pc_bus, 16'h0);
`ifdef PC_RAS_ERR_EN
    chk("clr_err", ras_err, 16'h0);
`endif
    clr_n = 1'b1;
    do_ret();
    chk("post_clr_ret", pc_q, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
